// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the bounded up/down counter.
//   mode_e  : counting mode encoding (matches the 2-bit mode port)
//   DIR_UP / DIR_DOWN : encoding of the dir output
package updown_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : updown_counter_pkg

// File: rtl/bounded_step.sv
// Clamped step arithmetic and range check for the bounded counter.
//   count, step, min_val, max_val : current value, step (0 means 1), bounds
//   up_next  : min(count + step, max_val), computed without modular wrap
//   dn_next  : max(count - step, min_val), computed without modular wrap
//   in_range : min_val <= count <= max_val
module bounded_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] up_next,
  output logic [WIDTH-1:0] dn_next,
  output logic             in_range
);

  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH-1:0] step_eff;
  logic [EW-1:0]    up_sum;
  logic [EW-1:0]    dn_diff;

  assign step_eff = (step == '0) ? WIDTH'(1) : step;

  // One extra bit carries the overflow/borrow so clamping sees the true result.
  assign up_sum  = {1'b0, count} + {1'b0, step_eff};
  assign dn_diff = {1'b0, count} - {1'b0, step_eff};

  assign up_next = (up_sum > {1'b0, max_val}) ? max_val : up_sum[WIDTH-1:0];
  assign dn_next = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < min_val))
                   ? min_val : dn_diff[WIDTH-1:0];

  assign in_range = (count >= min_val) && (count <= max_val);

endmodule : bounded_step

// File: rtl/updown_counter_param.sv
// Parametrised bounded up/down counter (sweep / sequence generator).
//   clock, resert      : rising-edge clock, synchronous active-high reset
//   en, mode, load     : count enable, counting mode, parallel load strobe
//   load_val           : value loaded (clamped into bounds) when load=1
//   min_val, max_val   : inclusive runtime bounds
//   step               : increment magnitude, 0 treated as 1
//   count, dir, tc     : registered count, direction, terminal-count pulse
//   at_min, at_max     : combinational boundary flags
//   cfg_err            : combinational, min_val > max_val (counter holds)
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter bit          DWELL = 1'b1
) (
  input  logic             clock,
  input  logic             resert,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_min,
  output logic             at_max,
  output logic             tc,
  output logic             cfg_err
);

  mode_e            mode_s;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic             in_range;
  logic [WIDTH-1:0] load_clamped;
  logic             eff_dir;

  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             tc_nxt;

  assign mode_s  = mode_e'(mode);
  assign at_min  = (count == min_val);
  assign at_max  = (count == max_val);
  assign cfg_err = (min_val > max_val);

  assign load_clamped = (load_val < min_val) ? min_val :
                        (load_val > max_val) ? max_val : load_val;

  // Direction used to pick the recovery endpoint when count is out of bounds.
  always_comb begin
    eff_dir = dir;
    case (mode_s)
      MODE_UP:   eff_dir = DIR_UP;
      MODE_DOWN: eff_dir = DIR_DOWN;
      default:   eff_dir = dir;
    endcase
  end

  bounded_step #(.WIDTH(WIDTH)) u_step (
    .count    (count),
    .step     (step),
    .min_val  (min_val),
    .max_val  (max_val),
    .up_next  (up_next),
    .dn_next  (dn_next),
    .in_range (in_range)
  );

  // Next-state: cfg_err > load > enable > mode.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    tc_nxt    = 1'b0;
    if (cfg_err) begin
      count_nxt = count;
    end else if (load) begin
      count_nxt = load_clamped;
    end else if (!en) begin
      count_nxt = count;
    end else if (mode_s != MODE_HOLD && !in_range) begin
      count_nxt = (eff_dir == DIR_UP) ? min_val : max_val;
      dir_nxt   = eff_dir;
    end else begin
      case (mode_s)
        MODE_UP: begin
          dir_nxt = DIR_UP;
          if (count == max_val) begin
            count_nxt = min_val;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = up_next;
          end
        end
        MODE_DOWN: begin
          dir_nxt = DIR_DOWN;
          if (count == min_val) begin
            count_nxt = max_val;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = dn_next;
          end
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (count == max_val) begin
              dir_nxt   = DIR_DOWN;
              tc_nxt    = 1'b1;
              count_nxt = DWELL ? count : dn_next;
            end else begin
              count_nxt = up_next;
            end
          end else begin
            if (count == min_val) begin
              dir_nxt   = DIR_UP;
              tc_nxt    = 1'b1;
              count_nxt = DWELL ? count : up_next;
            end else begin
              count_nxt = dn_next;
            end
          end
        end
        default: begin
          count_nxt = count;
        end
      endcase
    end
  end

  // State register with synchronous reset to the lower bound.
  always_ff @(posedge clock) begin
    if (resert) begin
      count <= min_val;
      dir   <= DIR_UP;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      dir   <= dir_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench for updown_counter_param (DWELL=1 and DWELL=0).
module tb_updown_counter_param;

  localparam int unsigned WIDTH = 4;

  logic             clock;
  logic             resert;
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] step;

  logic [WIDTH-1:0] count,  count0;
  logic             dir,    dir0;
  logic             at_min, at_min0;
  logic             at_max, at_max0;
  logic             tc,     tc0;
  logic             cfg_err, cfg_err0;

  int checks;
  int errors;

  updown_counter_param #(.WIDTH(WIDTH), .DWELL(1'b1)) u_dut (
    .clock(clock), .resert(resert), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .min_val(min_val), .max_val(max_val), .step(step),
    .count(count), .dir(dir), .at_min(at_min), .at_max(at_max), .tc(tc),
    .cfg_err(cfg_err)
  );

  updown_counter_param #(.WIDTH(WIDTH), .DWELL(1'b0)) u_dut0 (
    .clock(clock), .resert(resert), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .min_val(min_val), .max_val(max_val), .step(step),
    .count(count0), .dir(dir0), .at_min(at_min0), .at_max(at_max0), .tc(tc0),
    .cfg_err(cfg_err0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int exp_c;
  int exp_d;
  int exp_t;
  int seq2_c [8] = '{3, 5, 7, 9, 7, 5, 3, 5};
  int seq2_t [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  int seq3_c [6] = '{2, 6, 10, 12, 2, 6};
  int seq3_t [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    checks = 0;
    errors = 0;

    // Test 1: DWELL=1 bounce 0..15 step 1
    resert = 1'b1; en = 1'b1; mode = 2'b10; load = 1'b0; load_val = '0;
    min_val = 4'd0; max_val = 4'd15; step = 4'd1;
    tick();
    check("t1_rst_count", int'(count), 0);
    check("t1_rst_dir", int'(dir), 0);
    check("t1_rst_tc", int'(tc), 0);
    check("t1_rst_at_min", int'(at_min), 1);
    resert = 1'b0;
    for (int i = 1; i < 34; i++) begin
      tick();
      if (i <= 15)      exp_c = i;
      else if (i == 16) exp_c = 15;
      else if (i <= 31) exp_c = 31 - i;
      else if (i == 32) exp_c = 0;
      else              exp_c = 1;
      exp_d = (i >= 16 && i <= 31) ? 1 : 0;
      exp_t = (i == 16 || i == 32) ? 1 : 0;
      check($sformatf("t1_count[%0d]", i), int'(count), exp_c);
      check($sformatf("t1_dir[%0d]", i), int'(dir), exp_d);
      check($sformatf("t1_tc[%0d]", i), int'(tc), exp_t);
    end

    // Test 2: DWELL=0 bounce 3..9 step 2
    resert = 1'b1; min_val = 4'd3; max_val = 4'd9; step = 4'd2;
    tick();
    resert = 1'b0;
    check("t2_count[0]", int'(count0), seq2_c[0]);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("t2_count[%0d]", i), int'(count0), seq2_c[i]);
      check($sformatf("t2_tc[%0d]", i), int'(tc0), seq2_t[i]);
    end

    // Test 3: up-wrap 2..12 step 4, then down-wrap step 0 from 3
    resert = 1'b1; mode = 2'b00; min_val = 4'd2; max_val = 4'd12; step = 4'd4;
    tick();
    resert = 1'b0;
    check("t3_count[0]", int'(count), seq3_c[0]);
    for (int i = 1; i < 6; i++) begin
      tick();
      check($sformatf("t3_count[%0d]", i), int'(count), seq3_c[i]);
      check($sformatf("t3_tc[%0d]", i), int'(tc), seq3_t[i]);
    end
    load = 1'b1; load_val = 4'd3;
    tick();
    check("t3_load3", int'(count), 3);
    load = 1'b0; mode = 2'b01; step = 4'd0;
    tick();
    check("t3_dn_count0", int'(count), 2);
    check("t3_dn_dir0", int'(dir), 1);
    check("t3_dn_tc0", int'(tc), 0);
    tick();
    check("t3_dn_count1", int'(count), 12);
    check("t3_dn_tc1", int'(tc), 1);
    tick();
    check("t3_dn_count2", int'(count), 11);
    check("t3_dn_tc2", int'(tc), 0);

    // Test 4: clamped load, then load together with reset
    load = 1'b1; load_val = 4'd14; max_val = 4'd9;
    tick();
    check("t4_load_clamp", int'(count), 9);
    check("t4_load_dir", int'(dir), 1);
    check("t4_load_tc", int'(tc), 0);
    check("t4_at_max", int'(at_max), 1);
    resert = 1'b1;
    tick();
    check("t4_rst_load_count", int'(count), 2);
    check("t4_rst_load_dir", int'(dir), 0);
    resert = 1'b0; load = 1'b0;

    // Test 5: freeze mid-descent, then degenerate bounce min=max=5
    min_val = 4'd0; max_val = 4'd15; step = 4'd1; mode = 2'b01;
    load = 1'b1; load_val = 4'd10;
    tick();
    load = 1'b0;
    tick();
    tick();
    check("t5_descent", int'(count), 8);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_hold_count[%0d]", i), int'(count), 8);
      check($sformatf("t5_hold_dir[%0d]", i), int'(dir), 1);
      check($sformatf("t5_hold_tc[%0d]", i), int'(tc), 0);
    end
    en = 1'b1; min_val = 4'd5; max_val = 4'd5; mode = 2'b10;
    tick();
    check("t5_recover_count", int'(count), 5);
    check("t5_recover_tc", int'(tc), 0);
    check("t5_recover_dir", int'(dir), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_eq_count[%0d]", i), int'(count), 5);
      check($sformatf("t5_eq_dir[%0d]", i), int'(dir), (i % 2 == 0) ? 0 : 1);
      check($sformatf("t5_eq_tc[%0d]", i), int'(tc), 1);
      check($sformatf("t5_eq_flags[%0d]", i), int'({at_min, at_max}), 3);
    end

    // Test 6: bad config, out-of-range recovery, reset mid-descent
    min_val = 4'd0; max_val = 4'd15; mode = 2'b00;
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    check("t6_load12", int'(count), 12);
    min_val = 4'd10; max_val = 4'd4;
    #1;
    check("t6_cfg_err", int'(cfg_err), 1);
    tick();
    check("t6_cfg_hold", int'(count), 12);
    check("t6_cfg_tc", int'(tc), 0);
    min_val = 4'd0; max_val = 4'd7;
    #1;
    check("t6_cfg_ok", int'(cfg_err), 0);
    tick();
    check("t6_oor_count", int'(count), 0);
    check("t6_oor_dir", int'(dir), 0);
    check("t6_oor_tc", int'(tc), 0);
    mode = 2'b01;
    tick();
    check("t6_dn_wrap", int'(count), 7);
    check("t6_dn_tc", int'(tc), 1);
    tick();
    check("t6_dn_count", int'(count), 6);
    check("t6_dn_dir", int'(dir), 1);
    resert = 1'b1;
    tick();
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_dir", int'(dir), 0);
    check("t6_rst_tc", int'(tc), 0);
    resert = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_updown_counter_param
